cnt_timer_sched: RTL and testbench

- Round-robin scheduler that shares one W-bit up-counter timer between NREQ requesters.
- Each requester asks for a timed interval of len+1 cycles. The scheduler grants one requester at a time, clears and runs the counter, compares it against the latched length, and pulses done back to the winner.
- Sits between the counter datapath (half-adder ripple counter with per-bit DFFs) and client blocks that need timed windows.

---
 rtl/cnt_timer_pkg.sv | 27 ++
 rtl/cnt_timer_core.sv | 32 +++
 rtl/cnt_timer_sched.sv | 90 +++++++++
 tb/tb_cnt_timer_sched.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/cnt_timer_pkg.sv
// cnt_timer_pkg: shared scheduler state type, limits and round-robin picker
package cnt_timer_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int NREQ_MAX = 8;

    // First requester found when scanning upward from last+1, wrapping at nreq
    function automatic logic [2:0] rr_pick(input logic [NREQ_MAX-1:0] req,
                                           input logic [2:0] last,
                                           input int nreq);
        logic [2:0] w;
        logic [2:0] k;
        logic f;
        w = '0;
        f = 1'b0;
        for (int i = 1; i <= NREQ_MAX; i++) begin
            k = 3'((int'(last) + i) % nreq);
            if (i <= nreq && !f && req[k]) begin
                w = k;
                f = 1'b1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/cnt_timer_core.sv
// cnt_timer_core: W-bit half-adder ripple up-counter with sync clear and enable
module cnt_timer_core #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         res,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q, q_d, sum;
    logic         cy;

    always_comb begin
        cy  = en;
        sum = '0;
        for (int i = 0; i < W; i++) begin
            sum[i] = q_q[i] ^ cy;
            cy     = q_q[i] & cy;
        end
        q_d = clr ? '0 : sum;
    end

    always_ff @(posedge clk) begin
        if (res) q_q <= '0;
        else     q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/cnt_timer_sched.sv
// cnt_timer_sched: round-robin scheduler sharing one interval timer among NREQ requesters
module cnt_timer_sched
    import cnt_timer_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 4
) (
    input  logic              clk,
    input  logic              res,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] len,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic [W-1:0]      cnt,
    output logic [NREQ-1:0]   done
);

    localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d, last_q, last_d;
    logic [W-1:0]    tc_q, tc_d;
    logic [W-1:0]    len_a [NREQ];
    logic [NREQ-1:0] sel;
    logic            clr, en, hit;

    always_comb begin
        for (int i = 0; i < NREQ; i++) len_a[i] = len[i*W +: W];
    end

    assign sel = {{(NREQ-1){1'b0}}, 1'b1} << idx_q;
    assign hit = cnt == tc_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        tc_d    = tc_q;
        if (state_q == IDLE && |req) begin
            idx_d   = IW'(rr_pick(NREQ_MAX'(req), 3'(last_q), NREQ));
            tc_d    = len_a[idx_d];
            state_d = RUN;
        end else if (state_q == RUN) begin
            state_d = !req[idx_q] ? IDLE : hit ? DONE : RUN;
            last_d  = !req[idx_q] ? idx_q : last_q;
        end else if (state_q == DONE) begin
            state_d = IDLE;
            last_d  = idx_q;
        end
    end

    // Counter is held at zero outside RUN and on abort, so every grant starts from 0
    assign clr = state_q != RUN || !req[idx_q];
    assign en  = state_q == RUN && !hit;

    cnt_timer_core #(.W(W)) u_core (
        .clk(clk),
        .res(res),
        .clr(clr),
        .en (en),
        .q  (cnt)
    );

    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= IDLE;
            idx_q   <= '0;
            last_q  <= IW'(NREQ - 1);
            tc_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            tc_q    <= tc_d;
        end
    end

    assign gnt  = state_q != IDLE ? sel : '0;
    assign done = state_q == DONE ? sel : '0;
    assign busy = state_q != IDLE;

    always_ff @(posedge clk) begin
        if (!res) begin
            assert ($onehot0(gnt));
            assert ((done & ~gnt) == '0);
            assert (busy == |gnt);
        end
    end

endmodule

// File: tb/tb_cnt_timer_sched.sv
// tb_cnt_timer_sched: directed checks of grant timing, round-robin order, abort and reset
module tb_cnt_timer_sched;

    logic        clk = 1'b0;
    logic        res;
    logic [3:0]  req;
    logic [15:0] len;
    logic [3:0]  gnt, done, cnt;
    logic        busy;
    int          npass = 0, ntot = 0, nfail = 0;

    cnt_timer_sched #(.NREQ(4), .W(4)) dut (
        .clk (clk),
        .res (res),
        .req (req),
        .len (len),
        .gnt (gnt),
        .busy(busy),
        .cnt (cnt),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_gnt"},  32'(gnt),  0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_cnt"},  32'(cnt),  0);
        chk({tag, "_done"}, 32'(done), 0);
    endtask

    initial begin
        int order [5] = '{0, 1, 2, 3, 0};
        res = 1'b1;
        req = '0;
        len = '0;
        tick();
        tick();
        chk_idle("reset");
        res = 1'b0;

        // single request, len0=3
        len = 16'h0003;
        req = 4'b0001;
        tick();
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_cnt0", 32'(cnt), 0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("t1_cnt", 32'(cnt), 32'(k));
            chk("t1_run_done", 32'(done), 0);
        end
        tick();
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_done_gnt", 32'(gnt), 32'h1);
        chk("t1_done_cnt", 32'(cnt), 3);
        req = '0;
        tick();
        chk_idle("t1_idle");

        // zero length on requester 2
        len = 16'h0000;
        req = 4'b0100;
        tick();
        chk("t2_gnt", 32'(gnt), 32'h4);
        chk("t2_run_done", 32'(done), 0);
        tick();
        chk("t2_done", 32'(done), 32'h4);
        chk("t2_done_gnt", 32'(gnt), 32'h4);
        req = '0;
        tick();
        chk_idle("t2_idle");

        // round-robin from reset, all len=1
        res = 1'b1;
        tick();
        res = 1'b0;
        len = 16'h1111;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 3; c++) begin
                tick();
                chk("t3_gnt", 32'(gnt), 32'(1 << order[g]));
                chk("t3_done", 32'(done), c == 2 ? 32'(1 << order[g]) : 0);
            end
            tick();
            chk("t3_gap", 32'(gnt), 0);
        end
        req = '0;
        tick();
        chk_idle("t3_idle");

        // abort requester 1 at cnt=5
        len = 16'h00F0;
        req = 4'b0010;
        tick();
        chk("t4_gnt", 32'(gnt), 32'h2);
        for (int k = 0; k < 5; k++) tick();
        chk("t4_cnt5", 32'(cnt), 5);
        req = '0;
        tick();
        chk_idle("t4_abort");
        req = 4'b0011;
        tick();
        chk("t4_next_gnt", 32'(gnt), 32'h1);
        tick();
        chk("t4_next_done", 32'(done), 32'h1);
        req = '0;
        tick();
        chk_idle("t4_idle");

        // reset at cnt=7 with len3=12, then re-grant requester 3
        len = 16'hC000;
        req = 4'b1000;
        tick();
        chk("t5_gnt", 32'(gnt), 32'h8);
        for (int k = 0; k < 7; k++) tick();
        chk("t5_cnt7", 32'(cnt), 7);
        res = 1'b1;
        tick();
        chk_idle("t5_reset");
        res = 1'b0;
        tick();
        chk("t5_regnt", 32'(gnt), 32'h8);
        chk("t5_regnt_cnt", 32'(cnt), 0);
        req = '0;
        tick();
        chk_idle("t5_abort");

        // max length 15
        len = 16'h000F;
        req = 4'b0001;
        tick();
        chk("t6_gnt", 32'(gnt), 32'h1);
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk("t6_cnt", 32'(cnt), 32'(k));
            chk("t6_run_gnt", 32'(gnt), 32'h1);
            chk("t6_run_done", 32'(done), 0);
        end
        tick();
        chk("t6_done", 32'(done), 32'h1);
        chk("t6_done_cnt", 32'(cnt), 15);
        req = '0;
        tick();
        chk_idle("t6_idle");

        $display("%0d/%0d checks passed", npass, ntot);
        if (nfail != 0) $error("%0d checks did not match", nfail);
        $finish;
    end

endmodule
